// File: rtl/riscv_cpu_pkg.sv
// Shared CPU types: writeback channel payload and load-size encoding.
package riscv_cpu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'b00,
        LSU_HALF = 2'b01,
        LSU_WORD = 2'b10
    } lsize_e;

    typedef struct packed {
        logic [XLEN-1:0]   data;
        logic [REG_AW-1:0] dest;
        logic              is_load;
        lsize_e            lsize;
        logic              lsigned;
        logic [1:0]        offset;
    } wb_chan_t;

endpackage

// File: rtl/wb_fifo.sv
// Pointer/count FIFO with registered full/empty flags; push and pop may coincide.
module wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  logic pop_i,
    input  T     data_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && !empty_q;
    assign do_push = push_i && (!full_q || do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage is not reset; the empty flag guards every read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/wb_stage_mc.sv
// Multi-channel writeback: per-channel FIFOs, round-robin grant to write ports,
// same-dest conflict skipping and load byte/half extraction.
module wb_stage_mc
    import riscv_cpu_pkg::*;
#(
    parameter int unsigned NR_CHANNELS = 3,
    parameter int unsigned NR_WPORTS   = 1,
    parameter int unsigned FIFO_DEPTH  = 2,
    parameter int unsigned DATA_WIDTH  = XLEN,
    parameter int unsigned ADDR_WIDTH  = REG_AW
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NR_CHANNELS-1:0]                ch_valid_i,
    output logic [NR_CHANNELS-1:0]                ch_ready_o,
    input  wb_chan_t [NR_CHANNELS-1:0]            ch_res_i,
    output logic [NR_WPORTS-1:0]                  we_o,
    output logic [NR_WPORTS-1:0][ADDR_WIDTH-1:0]  dest_reg_o,
    output logic [NR_WPORTS-1:0][DATA_WIDTH-1:0]  wdata_o,
    output logic                                  load_err_o
);

    localparam int unsigned RR_W = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1;

    wb_chan_t                head [NR_CHANNELS];
    logic [NR_CHANNELS-1:0]  full, empty, pop;
    logic [RR_W-1:0]         rr_q, rr_d;
    wb_chan_t                gnt_res [NR_WPORTS];
    logic [NR_WPORTS-1:0]    gnt_vld, mis;
    logic [XLEN-1:0]         fmt_data [NR_WPORTS];

    logic [NR_WPORTS-1:0]                 we_q;
    logic [NR_WPORTS-1:0][ADDR_WIDTH-1:0] dest_q;
    logic [NR_WPORTS-1:0][DATA_WIDTH-1:0] wdata_q;
    logic                                 err_q;

    for (genvar g = 0; g < NR_CHANNELS; g++) begin : g_ch
        wb_fifo #(.DEPTH(FIFO_DEPTH), .T(wb_chan_t)) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (ch_valid_i[g] && !full[g]),
            .pop_i   (pop[g]),
            .data_i  (ch_res_i[g]),
            .data_o  (head[g]),
            .full_o  (full[g]),
            .empty_o (empty[g])
        );
    end

    assign ch_ready_o = ~full;

    // Round-robin scan from rr_q; a head whose dest matches an earlier grant waits.
    always_comb begin
        int       nr_grant;
        int       idx;
        int       last_ch;
        wb_chan_t cand;
        logic     cand_vld;
        logic     conflict;
        pop      = '0;
        gnt_vld  = '0;
        for (int k = 0; k < NR_WPORTS; k++) gnt_res[k] = '0;
        nr_grant = 0;
        last_ch  = 0;
        idx      = 0;
        cand     = '0;
        cand_vld = 1'b0;
        conflict = 1'b0;
        for (int i = 0; i < NR_CHANNELS; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= int'(NR_CHANNELS)) idx = idx - int'(NR_CHANNELS);
            cand     = '0;
            cand_vld = 1'b0;
            for (int j = 0; j < NR_CHANNELS; j++) begin
                if (j == idx) begin
                    cand     = head[j];
                    cand_vld = !empty[j];
                end
            end
            conflict = 1'b0;
            for (int k = 0; k < NR_WPORTS; k++) begin
                if (k < nr_grant && gnt_res[k].dest == cand.dest) conflict = 1'b1;
            end
            if (cand_vld && nr_grant < int'(NR_WPORTS) && !conflict) begin
                for (int j = 0; j < NR_CHANNELS; j++) begin
                    if (j == idx) pop[j] = 1'b1;
                end
                for (int k = 0; k < NR_WPORTS; k++) begin
                    if (k == nr_grant) begin
                        gnt_vld[k] = 1'b1;
                        gnt_res[k] = cand;
                    end
                end
                last_ch  = idx;
                nr_grant = nr_grant + 1;
            end
        end
        rr_d = rr_q;
        if (nr_grant > 0) begin
            rr_d = (last_ch + 1 >= int'(NR_CHANNELS)) ? '0 : RR_W'(last_ch + 1);
        end
    end

    // Load lane extraction and extension; misaligned half/word loads are flagged.
    always_comb begin
        logic [XLEN-1:0] shifted;
        shifted = '0;
        for (int k = 0; k < NR_WPORTS; k++) begin
            shifted     = gnt_res[k].data >> {gnt_res[k].offset, 3'b000};
            fmt_data[k] = gnt_res[k].data;
            mis[k]      = 1'b0;
            if (gnt_res[k].is_load) begin
                case (gnt_res[k].lsize)
                    LSU_BYTE: fmt_data[k] = {{(XLEN-8){gnt_res[k].lsigned & shifted[7]}}, shifted[7:0]};
                    LSU_HALF: begin
                        fmt_data[k] = {{(XLEN-16){gnt_res[k].lsigned & shifted[15]}}, shifted[15:0]};
                        mis[k]      = gnt_res[k].offset[0];
                    end
                    LSU_WORD: mis[k] = (gnt_res[k].offset != 2'b00);
                    default:  fmt_data[k] = gnt_res[k].data;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q    <= '0;
            we_q    <= '0;
            dest_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            rr_q  <= rr_d;
            err_q <= |(gnt_vld & mis);
            for (int k = 0; k < NR_WPORTS; k++) begin
                we_q[k] <= gnt_vld[k] && (gnt_res[k].dest != '0) && !mis[k];
                if (gnt_vld[k]) begin
                    dest_q[k]  <= ADDR_WIDTH'(gnt_res[k].dest);
                    wdata_q[k] <= DATA_WIDTH'(fmt_data[k]);
                end
            end
        end
    end

    assign we_o       = we_q;
    assign dest_reg_o = dest_q;
    assign wdata_o    = wdata_q;
    assign load_err_o = err_q;

endmodule

// File: tb/tb_wb_stage_mc.sv
// Directed bench: one single-port and one dual-port writeback stage instance.
module tb_wb_stage_mc;
    import riscv_cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]       vld_a, rdy_a, vld_b, rdy_b;
    wb_chan_t [2:0]   res_a, res_b;
    logic [0:0]       we_a;
    logic [0:0][4:0]  dest_a;
    logic [0:0][31:0] wdata_a;
    logic             err_a;
    logic [1:0]       we_b;
    logic [1:0][4:0]  dest_b;
    logic [1:0][31:0] wdata_b;
    logic             err_b;

    int n_vec = 0;
    int n_bad = 0;

    wb_stage_mc #(.NR_CHANNELS(3), .NR_WPORTS(1)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .ch_valid_i(vld_a), .ch_ready_o(rdy_a),
        .ch_res_i(res_a), .we_o(we_a), .dest_reg_o(dest_a), .wdata_o(wdata_a),
        .load_err_o(err_a)
    );

    wb_stage_mc #(.NR_CHANNELS(3), .NR_WPORTS(2)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .ch_valid_i(vld_b), .ch_ready_o(rdy_b),
        .ch_res_i(res_b), .we_o(we_b), .dest_reg_o(dest_b), .wdata_o(wdata_b),
        .load_err_o(err_b)
    );

    // Stimulus never offers a result to a full buffer.
    always @(posedge clk) begin
        if (rst_n) begin
            assert ((vld_a & ~rdy_a) == 3'b000) else $error("FAIL push_full_a vld=%b rdy=%b", vld_a, rdy_a);
            assert ((vld_b & ~rdy_b) == 3'b000) else $error("FAIL push_full_b vld=%b rdy=%b", vld_b, rdy_b);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic wb_chan_t mk(input logic [31:0] data, input logic [4:0] dest,
                                    input logic is_load, input lsize_e lsize,
                                    input logic lsigned, input logic [1:0] off);
        wb_chan_t r;
        r.data = data; r.dest = dest; r.is_load = is_load;
        r.lsize = lsize; r.lsigned = lsigned; r.offset = off;
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        vld_a = '0;
        vld_b = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int pushed [3];
        int got_seq [3];
        int exp_ch;
        int nwr;
        int npush;
        int ch;
        logic dropped;

        vld_a = '0; vld_b = '0; res_a = '0; res_b = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_we", 64'(we_a), 64'h0);
        chk("rst_dest", 64'(dest_a[0]), 64'h0);
        chk("rst_wdata", 64'(wdata_a[0]), 64'h0);
        chk("rst_err", 64'(err_a), 64'h0);
        chk("rst_we_b", 64'(we_b), 64'h0);
        step(); step();
        rst_n = 1'b1;
        step();
        chk("rst_ready", 64'(rdy_a), 64'h7);

        // Plain ALU result, two-cycle latency
        res_a[0] = mk(32'h1234_5678, 5'd5, 1'b0, LSU_WORD, 1'b0, 2'd0);
        vld_a = 3'b001;
        step();
        vld_a = '0;
        chk("alu_early_we", 64'(we_a), 64'h0);
        step();
        chk("alu_we", 64'(we_a), 64'h1);
        chk("alu_dest", 64'(dest_a[0]), 64'd5);
        chk("alu_wdata", 64'(wdata_a[0]), 64'h1234_5678);
        step();
        chk("idle_we", 64'(we_a), 64'h0);
        chk("idle_dest_hold", 64'(dest_a[0]), 64'd5);

        // Load formatting
        res_a[1] = mk(32'h0080_0000, 5'd3, 1'b1, LSU_BYTE, 1'b1, 2'd2);
        vld_a = 3'b010;
        step();
        vld_a = '0;
        step();
        chk("lb_we", 64'(we_a), 64'h1);
        chk("lb_wdata", 64'(wdata_a[0]), 64'hFFFF_FF80);
        res_a[1] = mk(32'hBEEF_0000, 5'd4, 1'b1, LSU_HALF, 1'b0, 2'd2);
        vld_a = 3'b010;
        step();
        vld_a = '0;
        step();
        chk("lhu_dest", 64'(dest_a[0]), 64'd4);
        chk("lhu_wdata", 64'(wdata_a[0]), 64'h0000_BEEF);

        // Saturating traffic on all channels, one write port
        do_reset();
        for (int c = 0; c < 3; c++) begin pushed[c] = 0; got_seq[c] = 0; end
        exp_ch = 0; nwr = 0; npush = 0; dropped = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (we_a[0]) begin
                ch = int'(wdata_a[0][17:16]);
                if (cyc < 24) begin
                    chk("rot_ch", 64'(ch), 64'(exp_ch));
                    exp_ch = (exp_ch + 1) % 3;
                end
                if (ch < 3) begin
                    chk("rot_seq", 64'(wdata_a[0][15:0]), 64'(got_seq[ch]));
                    got_seq[ch]++;
                end
                nwr++;
            end
            if (rdy_a != 3'b111) dropped = 1'b1;
            for (int c = 0; c < 3; c++) begin
                if (cyc < 24 && rdy_a[c]) begin
                    vld_a[c] = 1'b1;
                    res_a[c] = mk({14'b0, 2'(c), 16'(pushed[c])}, 5'(c + 1), 1'b0, LSU_WORD, 1'b0, 2'd0);
                    pushed[c]++;
                    npush++;
                end else begin
                    vld_a[c] = 1'b0;
                end
            end
            step();
        end
        chk("rot_ready_dropped", 64'(dropped), 64'h1);
        chk("rot_count", 64'(nwr), 64'(npush));
        for (int c = 0; c < 3; c++) chk("rot_per_ch", 64'(got_seq[c]), 64'(pushed[c]));

        // Same-dest conflict and dual-port grant
        do_reset();
        res_b[0] = mk(32'hAAAA_0000, 5'd7, 1'b0, LSU_WORD, 1'b0, 2'd0);
        res_b[1] = mk(32'hBBBB_0000, 5'd7, 1'b0, LSU_WORD, 1'b0, 2'd0);
        vld_b = 3'b011;
        step();
        vld_b = '0;
        step();
        chk("waw_we1", 64'(we_b), 64'h1);
        chk("waw_dest1", 64'(dest_b[0]), 64'd7);
        chk("waw_wdata1", 64'(wdata_b[0]), 64'hAAAA_0000);
        step();
        chk("waw_we2", 64'(we_b), 64'h1);
        chk("waw_wdata2", 64'(wdata_b[0]), 64'hBBBB_0000);
        res_b[0] = mk(32'hC0C0_0000, 5'd8, 1'b0, LSU_WORD, 1'b0, 2'd0);
        res_b[2] = mk(32'hC2C2_0000, 5'd9, 1'b0, LSU_WORD, 1'b0, 2'd0);
        vld_b = 3'b101;
        step();
        vld_b = '0;
        step();
        chk("dual_we", 64'(we_b), 64'h3);
        chk("dual_wdata0", 64'(wdata_b[0]), 64'hC2C2_0000);
        chk("dual_wdata1", 64'(wdata_b[1]), 64'hC0C0_0000);
        chk("dual_dest1", 64'(dest_b[1]), 64'd8);

        // Misaligned load, then x0 write, then a normal write
        do_reset();
        res_a[0] = mk(32'h1122_3344, 5'd6, 1'b1, LSU_WORD, 1'b0, 2'd1);
        vld_a = 3'b001;
        step();
        res_a[0] = mk(32'h5555_5555, 5'd0, 1'b0, LSU_WORD, 1'b0, 2'd0);
        step();
        chk("mis_we", 64'(we_a), 64'h0);
        chk("mis_err", 64'(err_a), 64'h1);
        res_a[0] = mk(32'h0000_CAFE, 5'd9, 1'b0, LSU_WORD, 1'b0, 2'd0);
        step();
        vld_a = '0;
        chk("x0_we", 64'(we_a), 64'h0);
        chk("x0_err", 64'(err_a), 64'h0);
        step();
        chk("post_we", 64'(we_a), 64'h1);
        chk("post_dest", 64'(dest_a[0]), 64'd9);
        chk("post_wdata", 64'(wdata_a[0]), 64'h0000_CAFE);
        chk("post_err", 64'(err_a), 64'h0);

        // Reset with buffered entries
        do_reset();
        for (int c = 0; c < 3; c++) res_a[c] = mk(32'hD000_0000 | 32'(c), 5'(c + 10), 1'b0, LSU_WORD, 1'b0, 2'd0);
        vld_a = 3'b111;
        step();
        vld_a = '0;
        step();
        chk("mid_we", 64'(we_a), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 64'(we_a), 64'h0);
        chk("mid_rst_dest", 64'(dest_a[0]), 64'h0);
        chk("mid_rst_wdata", 64'(wdata_a[0]), 64'h0);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stale_we", 64'(we_a), 64'h0);
            chk("stale_ready", 64'(rdy_a), 64'h7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
